// File: rtl/sp_ram_rr_arbiter.sv
// Single-port read-first RAM shared by NREQ requesters through a round-robin
// arbiter with valid/ready handshakes, a tagged read-response channel and an
// optional post-reset zero-fill sweep.
module sp_ram_rr_arbiter #(
    parameter int unsigned ABITS         = 12,
    parameter int unsigned WIDTH         = 72,
    parameter int unsigned NREQ          = 4,
    parameter int unsigned INIT_ON_RESET = 1,
    localparam int unsigned IDW          = $clog2(NREQ),
    localparam int unsigned DEPTH        = 2 ** ABITS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_write,
    input  logic [NREQ*ABITS-1:0]   req_addr,
    input  logic [NREQ*WIDTH-1:0]   req_wdata,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    output logic [IDW-1:0]          rsp_id,
    output logic [WIDTH-1:0]        rsp_rdata,
    output logic                    init_done
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 r_state;
    logic [ABITS-1:0]       r_init_addr;
    logic [IDW-1:0]         r_rr_ptr;
    logic [WIDTH-1:0]       r_mem [DEPTH];
    logic                   r_rsp_valid;
    logic [IDW-1:0]         r_rsp_id;
    logic [WIDTH-1:0]       r_rsp_rdata;

    logic                   w_any;
    logic [IDW-1:0]         w_gnt_idx;
    logic [IDW-1:0]         w_next_ptr;
    logic [NREQ-1:0]        w_ready;
    logic [ABITS-1:0]       w_addr  [NREQ];
    logic [WIDTH-1:0]       w_wdata [NREQ];
    logic [ABITS-1:0]       w_sel_addr;
    logic [WIDTH-1:0]       w_sel_wdata;
    logic                   w_sel_write;

    // Unpack the per-requester address and data buses
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_addr[g]  = req_addr[g*ABITS +: ABITS];
        assign w_wdata[g] = req_wdata[g*WIDTH +: WIDTH];
    end

    // Round-robin search starting at r_rr_ptr; no grant in INIT or reset
    always_comb begin
        w_any     = 1'b0;
        w_gnt_idx = '0;
        if (rst_n && (r_state == ST_RUN)) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                if (!w_any && req_valid[IDW'((32'(r_rr_ptr) + k) % NREQ)]) begin
                    w_any     = 1'b1;
                    w_gnt_idx = IDW'((32'(r_rr_ptr) + k) % NREQ);
                end
            end
        end
    end

    // One-hot ready, selected request fields and wrapped next pointer
    always_comb begin
        w_ready = '0;
        if (w_any) begin
            w_ready[w_gnt_idx] = 1'b1;
        end
        w_sel_addr  = w_addr[w_gnt_idx];
        w_sel_wdata = w_wdata[w_gnt_idx];
        w_sel_write = req_write[w_gnt_idx];
        if (w_gnt_idx == IDW'(NREQ - 1)) begin
            w_next_ptr = '0;
        end else begin
            w_next_ptr = w_gnt_idx + 1'b1;
        end
    end

    // Control FSM: zero-fill sweep, then arbitration pointer updates
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
            r_init_addr <= '0;
            r_rr_ptr    <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_init_addr <= r_init_addr + 1'b1;
                    if (r_init_addr == {ABITS{1'b1}}) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_any) begin
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // Array write port: sweep zeroes in INIT, granted writes in RUN
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (r_state == ST_INIT) begin
                r_mem[r_init_addr] <= '0;
            end else if (w_any && w_sel_write) begin
                r_mem[w_sel_addr] <= w_sel_wdata;
            end
        end
    end

    // Read-first response register; id/data hold between responses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_any && !w_sel_write;
            if (w_any && !w_sel_write) begin
                r_rsp_id    <= w_gnt_idx;
                r_rsp_rdata <= r_mem[w_sel_addr];
            end
        end
    end

    assign req_ready = w_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_rdata = r_rsp_rdata;
    assign init_done = (r_state == ST_RUN);

endmodule

// File: tb/tb_sp_ram_rr_arbiter.sv
// Bench for sp_ram_rr_arbiter: directed plan steps plus random traffic, all
// checked against a transaction-level model of arbitration, RAM and responses.
module tb_sp_ram_rr_arbiter;

    localparam int unsigned ABITS = 4;
    localparam int unsigned WIDTH = 72;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned DEPTH = 16;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_write;
    logic [NREQ*ABITS-1:0] req_addr;
    logic [NREQ*WIDTH-1:0] req_wdata;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [1:0]            rsp_id;
    logic [WIDTH-1:0]      rsp_rdata;
    logic                  init_done;

    always #5 clk = ~clk;

    sp_ram_rr_arbiter #(
        .ABITS(ABITS), .WIDTH(WIDTH), .NREQ(NREQ), .INIT_ON_RESET(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
        .init_done(init_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Requester-side pending transactions
    logic             r_rst;
    logic             p_valid [NREQ];
    logic             p_write [NREQ];
    logic [ABITS-1:0] p_addr  [NREQ];
    logic [WIDTH-1:0] p_wdata [NREQ];
    int               mode;

    // Reference model state
    logic [WIDTH-1:0] m_mem [DEPTH];
    logic             m_run;
    int               m_icnt;
    int               m_ptr;
    logic             e_v;
    int               e_id;
    logic [WIDTH-1:0] e_rd;

    // One-shot directed expectations
    logic             x_rdy_en;
    logic [NREQ-1:0]  x_rdy;
    logic             x_rsp_en;
    int               x_id;
    logic [WIDTH-1:0] x_rd;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        rst_n = r_rst;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]                 = p_valid[i];
            req_write[i]                 = p_write[i];
            req_addr[i*ABITS +: ABITS]   = p_addr[i];
            req_wdata[i*WIDTH +: WIDTH]  = p_wdata[i];
        end
    endtask

    task automatic set_req(input int i, input logic wr, input int a, input logic [WIDTH-1:0] d);
        p_valid[i] = 1'b1;
        p_write[i] = wr;
        p_addr[i]  = ABITS'(a);
        p_wdata[i] = d;
        drive();
    endtask

    task automatic rand_req(input int i, input logic wr);
        p_valid[i] = 1'b1;
        p_write[i] = wr;
        p_addr[i]  = ABITS'($urandom_range(0, DEPTH - 1));
        p_wdata[i] = WIDTH'({$urandom, $urandom, $urandom});
    endtask

    task automatic expect_ready(input logic [NREQ-1:0] r);
        x_rdy_en = 1'b1;
        x_rdy    = r;
    endtask

    task automatic expect_rsp(input int id, input logic [WIDTH-1:0] d);
        x_rsp_en = 1'b1;
        x_id     = id;
        x_rd     = d;
    endtask

    task automatic reset_model();
        m_run  = 1'b0;
        m_icnt = 0;
        m_ptr  = 0;
        e_v    = 1'b0;
        e_id   = 0;
        e_rd   = '0;
    endtask

    // Each cycle: check outputs at negedge, advance model, then new stimulus after posedge
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            int g;
            logic [NREQ-1:0] er;
            @(negedge clk);
            g  = -1;
            er = '0;
            if (r_rst && m_run) begin
                for (int k = 0; k < NREQ; k++) begin
                    int idx;
                    idx = (m_ptr + k) % NREQ;
                    if (g < 0 && p_valid[idx]) g = idx;
                end
            end
            if (g >= 0) er[g] = 1'b1;
            chk("req_ready", req_ready, er);
            chk("init_done", init_done, m_run);
            chk("rsp_valid", rsp_valid, e_v);
            chk("rsp_id", rsp_id, e_id);
            chk("rsp_rdata", rsp_rdata, e_rd);
            if (x_rdy_en) begin
                chk("plan_ready", req_ready, x_rdy);
                x_rdy_en = 1'b0;
            end
            if (x_rsp_en) begin
                chk("plan_rsp_valid", rsp_valid, 1'b1);
                chk("plan_rsp_id", rsp_id, x_id);
                chk("plan_rsp_rdata", rsp_rdata, x_rd);
                x_rsp_en = 1'b0;
            end
            if (!r_rst) begin
                reset_model();
            end else if (!m_run) begin
                m_mem[m_icnt] = '0;
                m_icnt++;
                if (m_icnt == DEPTH) m_run = 1'b1;
                e_v = 1'b0;
            end else begin
                e_v = 1'b0;
                if (g >= 0) begin
                    if (p_write[g]) begin
                        m_mem[p_addr[g]] = p_wdata[g];
                    end else begin
                        e_v  = 1'b1;
                        e_id = g;
                        e_rd = m_mem[p_addr[g]];
                    end
                    m_ptr = (g + 1) % NREQ;
                end
            end
            @(posedge clk);
            #1;
            if (g >= 0) p_valid[g] = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (!p_valid[i]) begin
                    if (mode == 1 && $urandom_range(0, 1) == 1) rand_req(i, 1'($urandom_range(0, 1)));
                    else if (mode == 2) rand_req(i, 1'b0);
                end
            end
            drive();
        end
    endtask

    initial begin
        r_rst    = 1'b0;
        mode     = 0;
        x_rdy_en = 1'b0;
        x_rdy    = '0;
        x_rsp_en = 1'b0;
        x_id     = 0;
        x_rd     = '0;
        for (int i = 0; i < NREQ; i++) begin
            p_valid[i] = 1'b0;
            p_write[i] = 1'b0;
            p_addr[i]  = '0;
            p_wdata[i] = '0;
        end
        reset_model();
        drive();
        @(posedge clk);
        #1;
        run(2);

        // Sweep with a waiting read from req2, then its response
        set_req(2, 1'b0, 5, '0);
        r_rst = 1'b1;
        drive();
        run(16);
        expect_ready(4'b0100);
        run(1);
        expect_rsp(2, '0);
        run(1);

        // Write then read-back by req1
        set_req(1, 1'b1, 3, WIDTH'('hA5));
        expect_ready(4'b0010);
        run(1);
        set_req(1, 1'b0, 3, '0);
        expect_ready(4'b0010);
        run(1);
        expect_rsp(1, WIDTH'('hA5));
        run(1);

        // Pointer at 2: req3 wins over req1
        set_req(1, 1'b0, 9, '0);
        set_req(3, 1'b0, 10, '0);
        expect_ready(4'b1000);
        run(1);
        expect_ready(4'b0010);
        run(2);

        // Move pointer to 0, then all four reading continuously
        set_req(3, 1'b0, 0, '0);
        run(1);
        mode = 2;
        for (int i = 0; i < NREQ; i++) rand_req(i, 1'b0);
        drive();
        expect_ready(4'b0001);
        run(8);
        mode = 0;
        run(5);

        // Same-cycle write by req0 and read by req1 of address 7
        set_req(0, 1'b1, 7, WIDTH'('h1234));
        set_req(1, 1'b0, 7, '0);
        expect_ready(4'b0001);
        run(1);
        expect_ready(4'b0010);
        run(1);
        expect_rsp(1, WIDTH'('h1234));
        run(1);

        // Random mixed traffic
        mode = 1;
        run(300);
        mode = 0;
        run(6);

        // Reset with a response in flight, then reset again mid-sweep
        set_req(0, 1'b0, 7, '0);
        run(1);
        r_rst = 1'b0;
        drive();
        run(2);
        r_rst = 1'b1;
        drive();
        run(7);
        r_rst = 1'b0;
        drive();
        run(2);
        r_rst = 1'b1;
        drive();
        run(17);

        // Random traffic over the re-zeroed array
        mode = 1;
        run(200);
        mode = 0;
        run(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
